// File: rtl/glitch_sequencer.sv
// Glitch attempt scheduler: per attempt requests a target reset, waits a swept
// delay, fires a glitch pulse of programmable width, then cools down.
module glitch_sequencer #(
    parameter int unsigned DELAY_W    = 16,
    parameter int unsigned WIDTH_W    = 8,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned RESET_HOLD = 12,
    parameter int unsigned COOLDOWN   = 4
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [DELAY_W-1:0] delay_base_i,
    input  logic [DELAY_W-1:0] delay_step_i,
    input  logic [WIDTH_W-1:0] glitch_width_i,
    input  logic [CNT_W-1:0]   attempts_i,
    output logic               rst_req_o,
    output logic               glitch_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               aborted_o,
    output logic [CNT_W-1:0]   attempt_o
);

    localparam int unsigned CFG_W = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;
    localparam int unsigned FIX_W = $clog2(((RESET_HOLD > COOLDOWN) ? RESET_HOLD : COOLDOWN) + 1);
    localparam int unsigned TMR_W = (CFG_W > FIX_W) ? CFG_W : FIX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_DELAY,
        S_GLITCH,
        S_COOLDOWN
    } state_t;

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   cnt, cnt_nxt;
    logic [DELAY_W-1:0] cur_delay, cur_delay_nxt;
    logic [DELAY_W-1:0] step_q;
    logic [WIDTH_W-1:0] width_q;
    logic [CNT_W-1:0]   last_q;
    logic [CNT_W-1:0]   attempt_nxt;
    logic               latch_cfg;
    logic [DELAY_W:0]   delay_sum;
    logic [TMR_W-1:0]   glitch_last;
    logic               rst_req_nxt, glitch_nxt, busy_nxt, done_nxt, aborted_nxt;

    assign delay_sum   = {1'b0, cur_delay} + {1'b0, step_q};
    assign glitch_last = (width_q == '0) ? '0 : TMR_W'(width_q) - TMR_W'(1);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt + TMR_W'(1);
        cur_delay_nxt = cur_delay;
        attempt_nxt   = attempt_o;
        latch_cfg     = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (start_i && !abort_i) begin
                    state_nxt     = S_RESET;
                    latch_cfg     = 1'b1;
                    cur_delay_nxt = delay_base_i;
                    attempt_nxt   = '0;
                end
            end
            S_RESET: begin
                if (cnt == TMR_W'(RESET_HOLD - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = (cur_delay == '0) ? S_GLITCH : S_DELAY;
                end
            end
            S_DELAY: begin
                if (cnt == TMR_W'(cur_delay) - TMR_W'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_GLITCH;
                end
            end
            S_GLITCH: begin
                if (cnt == glitch_last) begin
                    cnt_nxt   = '0;
                    state_nxt = S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                if (cnt == TMR_W'(COOLDOWN - 1)) begin
                    cnt_nxt = '0;
                    if (attempt_o == last_q) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt     = S_RESET;
                        attempt_nxt   = attempt_o + CNT_W'(1);
                        cur_delay_nxt = delay_sum[DELAY_W] ? '1 : delay_sum[DELAY_W-1:0];
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (abort_i && state != S_IDLE) begin
            state_nxt     = S_IDLE;
            cnt_nxt       = '0;
            cur_delay_nxt = cur_delay;
            attempt_nxt   = attempt_o;
        end

        // Outputs are registered from the next state so they line up with the state they describe.
        rst_req_nxt = (state_nxt == S_RESET) && (state != S_RESET);
        glitch_nxt  = (state_nxt == S_GLITCH);
        busy_nxt    = (state_nxt != S_IDLE);
        done_nxt    = (state == S_COOLDOWN) && (state_nxt == S_IDLE) && !abort_i;
        aborted_nxt = abort_i && (state != S_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cur_delay <= '0;
            step_q    <= '0;
            width_q   <= '0;
            last_q    <= '0;
            attempt_o <= '0;
            rst_req_o <= 1'b0;
            glitch_o  <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            aborted_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cur_delay <= cur_delay_nxt;
            attempt_o <= attempt_nxt;
            rst_req_o <= rst_req_nxt;
            glitch_o  <= glitch_nxt;
            busy_o    <= busy_nxt;
            done_o    <= done_nxt;
            aborted_o <= aborted_nxt;
            if (latch_cfg) begin
                step_q  <= delay_step_i;
                width_q <= glitch_width_i;
                last_q  <= (attempts_i == '0) ? '0 : attempts_i - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Scoreboard bench for glitch_sequencer: expected output events (cycle, kind, attempt)
// are queued by the stimulus and checked by an independent monitor.
module tb_glitch_sequencer;

    typedef enum logic [2:0] {EV_BUSY_ON, EV_BUSY_OFF, EV_RST, EV_GLT, EV_DONE, EV_ABT} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        int unsigned cyc;
        logic [7:0]  att;
    } ev_t;

    ev_t         exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned t0, t1;
    logic        mon_en = 1'b0;
    logic        busy_prev = 1'b0;
    logic        sel = 1'b0;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        start_m = 1'b0, start_s = 1'b0, abort_m = 1'b0, abort_s = 1'b0;
    logic [15:0] base_m = '0, step_m = '0;
    logic [3:0]  base_s = '0, step_s = '0;
    logic [7:0]  width = '0, attempts = '0;

    logic        m_rst_req, m_glitch, m_busy, m_done, m_aborted;
    logic        s_rst_req, s_glitch, s_busy, s_done, s_aborted;
    logic [7:0]  m_att, s_att;
    logic        mon_rst_req, mon_glitch, mon_busy, mon_done, mon_aborted;
    logic [7:0]  mon_att;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    glitch_sequencer #(.DELAY_W(16), .WIDTH_W(8), .CNT_W(8), .RESET_HOLD(12), .COOLDOWN(4)) dut (
        .clk_in(clk_in), .rst(rst), .start_i(start_m), .abort_i(abort_m),
        .delay_base_i(base_m), .delay_step_i(step_m), .glitch_width_i(width), .attempts_i(attempts),
        .rst_req_o(m_rst_req), .glitch_o(m_glitch), .busy_o(m_busy), .done_o(m_done),
        .aborted_o(m_aborted), .attempt_o(m_att)
    );

    // Narrow delay instance so delay saturation is reachable in a short run.
    glitch_sequencer #(.DELAY_W(4), .WIDTH_W(8), .CNT_W(8), .RESET_HOLD(12), .COOLDOWN(4)) dut_sat (
        .clk_in(clk_in), .rst(rst), .start_i(start_s), .abort_i(abort_s),
        .delay_base_i(base_s), .delay_step_i(step_s), .glitch_width_i(width), .attempts_i(attempts),
        .rst_req_o(s_rst_req), .glitch_o(s_glitch), .busy_o(s_busy), .done_o(s_done),
        .aborted_o(s_aborted), .attempt_o(s_att)
    );

    assign mon_rst_req = sel ? s_rst_req : m_rst_req;
    assign mon_glitch  = sel ? s_glitch  : m_glitch;
    assign mon_busy    = sel ? s_busy    : m_busy;
    assign mon_done    = sel ? s_done    : m_done;
    assign mon_aborted = sel ? s_aborted : m_aborted;
    assign mon_att     = sel ? s_att     : m_att;

    function automatic void expect_ev(ev_kind_t k, int unsigned c, logic [7:0] a);
        ev_t e;
        int  i = 0;
        e.kind = k; e.cyc = c; e.att = a;
        while (i < exp_q.size() && (exp_q[i].cyc < c || (exp_q[i].cyc == c && exp_q[i].kind <= k)))
            i++;
        exp_q.insert(i, e);
    endfunction

    task automatic observe(ev_kind_t k);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s cyc=%0d att=%0d, required no event",
                     k.name(), cyc, mon_att);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.att != mon_att) begin
                errors++;
                $display("FAIL event: got %s cyc=%0d att=%0d, required %s cyc=%0d att=%0d",
                         k.name(), cyc, mon_att, e.kind.name(), e.cyc, e.att);
            end
        end
    endtask

    always @(negedge clk_in) begin
        if (mon_en) begin
            if (mon_busy != busy_prev) observe(mon_busy ? EV_BUSY_ON : EV_BUSY_OFF);
            if (mon_rst_req) observe(EV_RST);
            if (mon_glitch)  observe(EV_GLT);
            if (mon_done)    observe(EV_DONE);
            if (mon_aborted) observe(EV_ABT);
            busy_prev = mon_busy;
        end
    end

    task automatic chk(string name, logic [12:0] act, logic [12:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic wait_cyc(int unsigned abs_cyc);
        while (cyc != abs_cyc) @(negedge clk_in);
    endtask

    task automatic drain(string name, int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d events still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (8) @(negedge clk_in);
    endtask

    function automatic logic [12:0] m_outs();
        return {m_rst_req, m_glitch, m_busy, m_done, m_aborted, m_att};
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk_in);
        chk("reset_outputs", m_outs(), '0);
        rst = 1'b0;
        mon_en = 1'b1;

        // 1: single shot
        base_m = 16'd5; step_m = 16'd0; width = 8'd3; attempts = 8'd1;
        @(negedge clk_in); t0 = cyc;
        expect_ev(EV_BUSY_ON, t0 + 1, 8'd0); expect_ev(EV_RST, t0 + 1, 8'd0);
        for (int k = 18; k <= 20; k++) expect_ev(EV_GLT, t0 + k, 8'd0);
        expect_ev(EV_BUSY_OFF, t0 + 25, 8'd0); expect_ev(EV_DONE, t0 + 25, 8'd0);
        start_m = 1'b1; @(negedge clk_in); start_m = 1'b0;
        drain("single_shot", 60);

        // 2: sweep 0, 2, 4
        base_m = 16'd0; step_m = 16'd2; width = 8'd1; attempts = 8'd3;
        @(negedge clk_in); t0 = cyc;
        expect_ev(EV_BUSY_ON, t0 + 1, 8'd0);
        expect_ev(EV_RST, t0 + 1, 8'd0);  expect_ev(EV_GLT, t0 + 13, 8'd0);
        expect_ev(EV_RST, t0 + 18, 8'd1); expect_ev(EV_GLT, t0 + 32, 8'd1);
        expect_ev(EV_RST, t0 + 37, 8'd2); expect_ev(EV_GLT, t0 + 53, 8'd2);
        expect_ev(EV_BUSY_OFF, t0 + 58, 8'd2); expect_ev(EV_DONE, t0 + 58, 8'd2);
        start_m = 1'b1; @(negedge clk_in); start_m = 1'b0;
        // Config changes after start must not affect the run.
        base_m = 16'd9; step_m = 16'd7; width = 8'd5; attempts = 8'd1;
        drain("sweep", 120);

        // 3: width=0 and attempts=0 both act as 1
        base_m = 16'd2; step_m = 16'd7; width = 8'd0; attempts = 8'd0;
        @(negedge clk_in); t0 = cyc;
        expect_ev(EV_BUSY_ON, t0 + 1, 8'd0); expect_ev(EV_RST, t0 + 1, 8'd0);
        expect_ev(EV_GLT, t0 + 15, 8'd0);
        expect_ev(EV_BUSY_OFF, t0 + 20, 8'd0); expect_ev(EV_DONE, t0 + 20, 8'd0);
        start_m = 1'b1; @(negedge clk_in); start_m = 1'b0;
        drain("edge_cfg", 60);

        // 4: saturation on 4-bit delay: 14 then 15 (not 3)
        sel = 1'b1;
        base_s = 4'd14; step_s = 4'd5; width = 8'd1; attempts = 8'd2;
        @(negedge clk_in); t0 = cyc;
        expect_ev(EV_BUSY_ON, t0 + 1, 8'd0);
        expect_ev(EV_RST, t0 + 1, 8'd0);  expect_ev(EV_GLT, t0 + 27, 8'd0);
        expect_ev(EV_RST, t0 + 32, 8'd1); expect_ev(EV_GLT, t0 + 59, 8'd1);
        expect_ev(EV_BUSY_OFF, t0 + 64, 8'd1); expect_ev(EV_DONE, t0 + 64, 8'd1);
        start_s = 1'b1; @(negedge clk_in); start_s = 1'b0;
        drain("saturation", 120);
        sel = 1'b0;

        // 5: abort during GLITCH, then immediate restart
        base_m = 16'd1; step_m = 16'd0; width = 8'd10; attempts = 8'd3;
        @(negedge clk_in); t0 = cyc;
        expect_ev(EV_BUSY_ON, t0 + 1, 8'd0); expect_ev(EV_RST, t0 + 1, 8'd0);
        expect_ev(EV_GLT, t0 + 14, 8'd0); expect_ev(EV_GLT, t0 + 15, 8'd0);
        expect_ev(EV_BUSY_OFF, t0 + 16, 8'd0); expect_ev(EV_ABT, t0 + 16, 8'd0);
        start_m = 1'b1; @(negedge clk_in); start_m = 1'b0;
        wait_cyc(t0 + 15);
        abort_m = 1'b1;
        @(negedge clk_in);
        abort_m = 1'b0;
        base_m = 16'd0; width = 8'd1; attempts = 8'd1;
        t1 = cyc;
        expect_ev(EV_BUSY_ON, t1 + 1, 8'd0); expect_ev(EV_RST, t1 + 1, 8'd0);
        expect_ev(EV_GLT, t1 + 13, 8'd0);
        expect_ev(EV_BUSY_OFF, t1 + 18, 8'd0); expect_ev(EV_DONE, t1 + 18, 8'd0);
        start_m = 1'b1; @(negedge clk_in); start_m = 1'b0;
        drain("abort_restart", 60);

        // 6a: rst during DELAY of attempt 1 clears everything silently
        base_m = 16'd8; step_m = 16'd0; width = 8'd1; attempts = 8'd2;
        @(negedge clk_in); t0 = cyc;
        expect_ev(EV_BUSY_ON, t0 + 1, 8'd0);
        expect_ev(EV_RST, t0 + 1, 8'd0);  expect_ev(EV_GLT, t0 + 21, 8'd0);
        expect_ev(EV_RST, t0 + 26, 8'd1);
        expect_ev(EV_BUSY_OFF, t0 + 41, 8'd0);
        start_m = 1'b1; @(negedge clk_in); start_m = 1'b0;
        wait_cyc(t0 + 40);
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        chk("midrun_rst_outputs", m_outs(), '0);
        drain("midrun_rst", 30);

        // 6b: start and abort together in IDLE: nothing happens
        base_m = 16'd0; attempts = 8'd1;
        start_m = 1'b1; abort_m = 1'b1;
        @(negedge clk_in);
        start_m = 1'b0; abort_m = 1'b0;
        chk("start_abort_idle", m_outs(), '0);
        repeat (4) @(negedge clk_in);
        chk("start_abort_idle_later", m_outs(), '0);
        drain("start_abort", 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
